// File: rtl/mem_sram_controller_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
//   - FSM state encoding for the two-halfword transfer sequencer
//   - SRAM geometry (18-bit halfword address, 16-bit data)
//   - default base address of data memory and the word-index helper
package mem_sram_controller_pkg;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam int          WORD_IDX_W        = SRAM_AW - 1;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

    // Word index inside data memory; the halfword address appends the half-select bit.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] address,
                                                          input logic [31:0] base_addr);
        return WORD_IDX_W'((address - base_addr) >> 2);
    endfunction

endpackage

// File: rtl/mem_sram_controller.sv
// Memory-stage controller for a 16-bit asynchronous SRAM.
// Splits each 32-bit load/store into a low and a high halfword access, each held
// on the pins for WAIT_CYCLES+1 cycles, and holds ready low so the pipeline
// freezes until the word completes.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rd_en, wr_en      load / store request from execute (write wins if both)
//   address           byte address, word aligned, offset by BASE_ADDR
//   write_data        store data
//   read_data         loaded word, registered, updated on entry to DONE
//   ready             1 = no transfer pending
//   sram_addr         halfword address {word_index, half}
//   sram_dq_out       write data to the pad
//   sram_dq_in        read data from the pad
//   sram_dq_oe        pad output enable (tristate assembled at board top)
//   sram_we_n         write strobe, active low
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; request is latched on the way out
// LOW   | low halfword (bits 15:0) on the pins for WAIT_CYCLES+1 cycles
// HIGH  | high halfword (bits 31:16) on the pins for WAIT_CYCLES+1 cycles
// DONE  | one cycle with ready high; pipeline advances on this edge
module mem_sram_controller
    import mem_sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES);

    sram_state_t             state;
    logic [WCW-1:0]          wait_cnt;
    logic                    op_write;
    logic [WORD_IDX_W-1:0]   word_idx;
    logic [31:0]             wdata_q;
    logic [SRAM_DW-1:0]      rbuf_lo;

    logic [WORD_IDX_W-1:0]   word_idx_in;
    logic                    in_half;
    logic                    half_last;
    logic                    req;

    assign req         = rd_en | wr_en;
    assign word_idx_in = word_index(address, BASE_ADDR);
    assign in_half     = (state == ST_LOW) || (state == ST_HIGH);
    assign half_last   = (wait_cnt == WAIT_LAST);

    assign ready      = !in_half && !((state == ST_IDLE) && req);
    assign sram_dq_oe = in_half && op_write;
    assign sram_we_n  = !(in_half && op_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            op_write    <= 1'b0;
            word_idx    <= '0;
            wdata_q     <= '0;
            rbuf_lo     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_write  <= wr_en;
                        word_idx  <= word_idx_in;
                        wdata_q   <= write_data;
                        sram_addr <= {word_idx_in, 1'b0};
                        if (wr_en) begin
                            sram_dq_out <= write_data[15:0];
                        end
                        wait_cnt <= '0;
                        state    <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (half_last) begin
                        if (!op_write) begin
                            rbuf_lo <= sram_dq_in;
                        end else begin
                            sram_dq_out <= wdata_q[31:16];
                        end
                        sram_addr <= {word_idx, 1'b1};
                        wait_cnt  <= '0;
                        state     <= ST_HIGH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (half_last) begin
                        // read_data only moves when a load finishes; stores leave it alone.
                        if (!op_write) begin
                            read_data <= {sram_dq_in, rbuf_lo};
                        end
                        wait_cnt <= '0;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_controller.sv
module tb_mem_sram_controller;
    import mem_sram_controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        rd_en_w0, wr_en_w0;
    logic [31:0] address_w0, write_data_w0, read_data_w0;
    logic        ready_w0;
    logic [17:0] sram_addr_w0;
    logic [15:0] sram_dq_out_w0;
    logic [15:0] sram_dq_in_w0 = 16'h0;
    logic        sram_dq_oe_w0, sram_we_n_w0;

    mem_sram_controller dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    mem_sram_controller #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .rd_en(rd_en_w0), .wr_en(wr_en_w0),
        .address(address_w0), .write_data(write_data_w0), .read_data(read_data_w0),
        .ready(ready_w0), .sram_addr(sram_addr_w0), .sram_dq_out(sram_dq_out_w0),
        .sram_dq_in(sram_dq_in_w0), .sram_dq_oe(sram_dq_oe_w0), .sram_we_n(sram_we_n_w0)
    );

    // Asynchronous SRAM model: combinational read, write while we_n is low.
    logic [15:0] mem [0:63];
    assign sram_dq_in = (sram_addr < 18'd64) ? mem[sram_addr[5:0]] : 16'h0;
    always @(posedge clk) begin
        if (!sram_we_n && sram_addr < 18'd64) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [17:0] addr; logic [15:0] dq; } strobe_t;
    typedef struct { int cyc; logic [31:0] rdata; } done_t;
    strobe_t sq[$];
    strobe_t sq0[$];
    done_t   dq_q[$];
    int      dq0_q[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the default instance.
    bit      prev_ready = 1'b1;
    int      low_run    = 0;
    strobe_t ms;
    done_t   md;
    always @(negedge clk) begin
        if (sram_we_n === 1'b0) begin
            if (sq.size() == 0) check("unexpected_strobe", {14'h0, sram_addr}, 32'hFFFF_FFFF);
            else begin
                ms = sq.pop_front();
                check("strobe_addr", {14'h0, sram_addr}, {14'h0, ms.addr});
                check("strobe_dq", {16'h0, sram_dq_out}, {16'h0, ms.dq});
                check("strobe_oe", {31'h0, sram_dq_oe}, 32'd1);
            end
        end
        if (mon_en && ready === 1'b1 && !prev_ready) begin
            if (dq_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                md = dq_q.pop_front();
                check("done_cycle", cyc, md.cyc);
                check("freeze_cycles", low_run, 32'd5);
                check("read_data", read_data, md.rdata);
            end
        end
        low_run    = (ready === 1'b1) ? 0 : low_run + 1;
        prev_ready = (ready === 1'b1);
    end

    // Monitor for the WAIT_CYCLES = 0 instance.
    bit      prev_ready0 = 1'b1;
    int      low_run0    = 0;
    strobe_t ms0;
    int      md0;
    always @(negedge clk) begin
        if (sram_we_n_w0 === 1'b0) begin
            if (sq0.size() == 0) check("w0_unexpected_strobe", {14'h0, sram_addr_w0}, 32'hFFFF_FFFF);
            else begin
                ms0 = sq0.pop_front();
                check("w0_strobe_addr", {14'h0, sram_addr_w0}, {14'h0, ms0.addr});
                check("w0_strobe_dq", {16'h0, sram_dq_out_w0}, {16'h0, ms0.dq});
            end
        end
        if (mon_en && ready_w0 === 1'b1 && !prev_ready0) begin
            if (dq0_q.size() == 0) check("w0_unexpected_done", 32'd1, 32'd0);
            else begin
                md0 = dq0_q.pop_front();
                check("w0_done_cycle", cyc, md0);
                check("w0_freeze_cycles", low_run0, 32'd3);
            end
        end
        low_run0    = (ready_w0 === 1'b1) ? 0 : low_run0 + 1;
        prev_ready0 = (ready_w0 === 1'b1);
    end

    // Called in cycle 0 (just after a rising edge); returns in the cycle after DONE.
    task automatic issue(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rdata);
        logic [16:0] widx;
        bit          seen;
        widx = 17'((a - 32'd1024) >> 2);
        rd_en = r; wr_en = w; address = a; write_data = wd;
        if (w) begin
            sq.push_back('{{widx, 1'b0}, wd[15:0]});
            sq.push_back('{{widx, 1'b0}, wd[15:0]});
            sq.push_back('{{widx, 1'b1}, wd[31:16]});
            sq.push_back('{{widx, 1'b1}, wd[31:16]});
        end
        dq_q.push_back('{cyc + 5, exp_rdata});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[4] = 16'h1234;
        mem[5] = 16'hABCD;
        rst = 1'b1;
        rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        rd_en_w0 = 0; wr_en_w0 = 0; address_w0 = 0; write_data_w0 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", {14'h0, sram_addr}, 32'h0);
        check("rst_dq_out", {16'h0, sram_dq_out}, 32'h0);
        check("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        check("rst_we_n", {31'h0, sram_we_n}, 32'h1);
        check("rst_ready", {31'h0, ready}, 32'h1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0);
        idle();
        issue(1'b1, 1'b0, 32'd1032, 32'h0, 32'hABCD1234);
        idle();
        issue(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 32'hABCD1234);
        idle();
        issue(1'b1, 1'b0, 32'd1028, 32'h0, 32'hCAFEF00D);
        issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);
        idle();

        // Reset during the first HIGH cycle of a store.
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
        sq.push_back('{18'd0, 16'h2222});
        sq.push_back('{18'd0, 16'h2222});
        sq.push_back('{18'd1, 16'h1111});
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_we_n", {31'h0, sram_we_n}, 32'h1);
        check("midrst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        check("midrst_read_data", read_data, 32'h0);
        check("midrst_ready", {31'h0, ready}, 32'h1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // WAIT_CYCLES = 0 store.
        wr_en_w0 = 1'b1; address_w0 = 32'd1024; write_data_w0 = 32'h5A5AA5A5;
        sq0.push_back('{18'd0, 16'hA5A5});
        sq0.push_back('{18'd1, 16'h5A5A});
        dq0_q.push_back(cyc + 3);
        seen0 = 1'b0;
        for (int i = 0; i < 20 && !seen0; i++) begin
            @(negedge clk);
            if (ready_w0 === 1'b1) seen0 = 1'b1;
        end
        if (!seen0) check("w0_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wr_en_w0 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("strobes_left", sq.size(), 32'd0);
        check("dones_left", dq_q.size(), 32'd0);
        check("w0_strobes_left", sq0.size(), 32'd0);
        check("w0_dones_left", dq0_q.size(), 32'd0);
        check("w0_read_data", read_data_w0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
